psm_seq: RTL and testbench
==========================

# psm_seq

Parametrised phase-sequencing state machine, the next generation of the fixed three-phase process machine. On a debounced Start_N falling edge it captures two operands and steps through NUM_PHASES timed phases, each with its own duration and logic operation. Adds Hold (pause), Abort (cancel), a one-cycle Done pulse and per-phase indication. Sits between the board-level push-button/switch inputs and the LED/7-segment output logic.

## Interface
- DATA_W, 3: operand and Dout width.
- NUM_PHASES, 3: number of phases, 1..8.
- CNT_W, 32: phase counter width.
- PHASE_TIME, {80_000_000, 10_000_000, 30_000_000}: packed [NUM_PHASES*CNT_W]; phase i duration in cycles at bits [i*CNT_W +: CNT_W]; every entry ≥1.
- PHASE_OP, {2'd2, 2'd1, 2'd0}: packed [NUM_PHASES*2]; phase i operation code at bits [i*2 +: 2].
- Clock  in  1  system clock; all state changes on rising edge.
- Reset_N  in  1  reset, asynchronous, active-low.
- Din1  in  DATA_W  operand A, captured on start.
- Din2  in  DATA_W  operand B, captured on start.
- Start_N  in  1  start request, active-low, level input; its falling edge is the start event.
- Hold  in  1  active-high pause.
- Abort  in  1  active-high synchronous cancel.
- Ready  out  1  idle, accepting start.
- Phase  out  NUM_PHASES  one-hot active phase; all zero when Ready.
- PhaseIdx  out  3  index of active phase; 0 when Ready.
- Dout  out  DATA_W  active phase result; 0 when Ready.
- Done  out  1  one-cycle pulse on normal completion of last phase.
- Aborted  out  1  one-cycle pulse on abort.

## Operation
- States: S_READY, S_RUN (with phase index register), no other states.
- Op codes: 0 = A|B, 1 = A^B, 2 = ~(~A & B), 3 = A&B; all bitwise over DATA_W.
- Start event: Start_N low at current edge and high at previous edge (one edge-history flop). Level held low is a single event.
- S_READY: start event and Abort low → capture A=Din1, B=Din2, phase 0, counter 0, enter S_RUN.
- S_RUN: counter increments each cycle; when counter+1 == PHASE_TIME[idx], counter clears and idx advances; after last phase → S_READY with Done.
- Hold high in S_RUN: counter and phase frozen; outputs unchanged.
- Abort high in S_RUN: → S_READY next edge, counter 0, Aborted pulses; Done not asserted.
- Priority in S_RUN: Abort > Hold > count.
- Start events during S_RUN are ignored and not queued; edge-history flop still tracks Start_N.
- Abort in S_READY has no effect except suppressing a simultaneous start.
- A/B hold last captured values until next start; Dout masks them to 0 in S_READY.
- Counter compare is CNT_W-bit unsigned; no wrap occurs for legal PHASE_TIME.

## Timing
- Reset (async assert, synchronous-release assumed upstream): S_READY, idx 0, counter 0, A=B=0, edge-history flop = 0 (Start_N treated as low), so Start_N held low through reset release does not start. Outputs: Ready=1, Phase=0, PhaseIdx=0, Dout=0, Done=0, Aborted=0.
- Start latency: start event at edge k → Ready=0, Phase[0]=1 from edge k.
- Phase i occupies exactly PHASE_TIME[i] cycles plus cycles with Hold high.
- Done and Aborted are high during the first S_READY cycle only; Ready=1 in the same cycle.
- A new start is accepted on the same edge on which Done/Aborted deassert at the earliest; a start event on the completion edge itself is ignored.
- All outputs decode registered state only; no combinational input-to-output path.
- Reset mid-run: immediate return to reset values, no Done/Aborted pulse.

## Structure
- Package psm_pkg: t_state enum, t_op enum (OP_OR, OP_XOR, OP_ORN, OP_AND), function or constants for op evaluation.
- Sub-module psm_alu: combinational, DATA_W parameter, inputs A, B, t_op, output result; instantiated once, op selected by PHASE_OP[idx].
- Counter, edge detect, state/idx registers in psm_seq top.

## Test plan
- PHASE_TIME={6,2,4}, PHASE_OP={2,1,0}, A=3'b101, B=3'b011 start → Phase0 4 cycles Dout=111, Phase1 2 cycles Dout=110, Phase2 6 cycles Dout=101, then Done one cycle with Ready=1.
- Hold high 3 cycles mid-phase1 → phase1 lasts 5 cycles, Dout stable, total run 15 cycles.
- Abort in cycle 2 of phase2 → Ready next edge, Aborted one pulse, Done never asserts, Dout=0.
- Start_N held low 20 cycles, then second falling edge during run → exactly one run, second edge ignored; new edge after Ready starts a fresh run with newly captured Din1/Din2.
- Start_N low through Reset_N release → no start; Reset_N asserted mid-phase1 → all outputs at reset values asynchronously.
- NUM_PHASES=1, PHASE_TIME={1}, PHASE_OP={3}, A=3'b110, B=3'b011 → one cycle Dout=010, then Done.

Source files
------------

// File: rtl/psm_pkg.sv
// rtl/psm_pkg.sv - shared types and constants for the psm_seq phase sequencer
//
// Purpose : state and operation enumerations used by psm_seq and psm_alu,
//           plus the widths that fix the phase-index and op-code fields.
// Contents: t_state (S_READY, S_RUN), t_op (OP_OR, OP_XOR, OP_ORN, OP_AND),
//           IDX_W, OP_W, MAX_PHASES, psm_op_from_bits().

package psm_pkg;

  // Phase index is always 3 bits wide so PhaseIdx keeps a fixed width
  // regardless of how many phases a particular build uses.
  localparam int IDX_W      = 3;
  localparam int OP_W       = 2;
  localparam int MAX_PHASES = 8;

  typedef enum logic {
    S_READY = 1'b0,
    S_RUN   = 1'b1
  } t_state;

  // Encodings match the raw op codes packed into PHASE_OP.
  typedef enum logic [OP_W-1:0] {
    OP_OR  = 2'd0,
    OP_XOR = 2'd1,
    OP_ORN = 2'd2,
    OP_AND = 2'd3
  } t_op;

  function automatic t_op psm_op_from_bits(input logic [OP_W-1:0] bits);
    return t_op'(bits);
  endfunction

endpackage

// File: rtl/psm_alu.sv
// rtl/psm_alu.sv - bitwise operation unit for the active phase
//
// Purpose : purely combinational evaluation of the phase operation on the
//           two captured operands.
// Ports   : i_a      [DATA_W] operand A
//           i_b      [DATA_W] operand B
//           i_op     t_op     operation selected by the active phase
//           o_result [DATA_W] bitwise result

module psm_alu
  import psm_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  t_op               i_op,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      // B-only bits are cleared; everything else is set.
      OP_ORN:  o_result = ~(~i_a & i_b);
      OP_AND:  o_result = i_a & i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/psm_seq.sv
// rtl/psm_seq.sv - parametrised phase-sequencing state machine
//
// Purpose : on a Start_N falling edge captures Din1/Din2 and walks through
//           NUM_PHASES timed phases, each applying its own bitwise op to the
//           captured operands. Supports Hold (pause) and Abort (cancel).
// Ports   : Clock      in   system clock, rising edge
//           Reset_N    in   asynchronous active-low reset
//           Din1       in   [DATA_W] operand A, captured on start
//           Din2       in   [DATA_W] operand B, captured on start
//           Start_N    in   active-low start level; falling edge = start event
//           Hold       in   pause counting while running
//           Abort      in   synchronous cancel
//           Ready      out  idle and accepting a start
//           Phase      out  [NUM_PHASES] one-hot active phase, 0 when Ready
//           PhaseIdx   out  [3] active phase index, 0 when Ready
//           Dout       out  [DATA_W] active phase result, 0 when Ready
//           Done       out  one-cycle pulse after the last phase completes
//           Aborted    out  one-cycle pulse after an abort
// All outputs decode registered state only.

module psm_seq
  import psm_pkg::*;
#(
  parameter int                            DATA_W     = 3,
  parameter int                            NUM_PHASES = 3,
  parameter int                            CNT_W      = 32,
  parameter logic [NUM_PHASES*CNT_W-1:0]   PHASE_TIME = {32'd80_000_000, 32'd10_000_000, 32'd30_000_000},
  parameter logic [NUM_PHASES*OP_W-1:0]    PHASE_OP   = {2'd2, 2'd1, 2'd0}
) (
  input  logic                  Clock,
  input  logic                  Reset_N,
  input  logic [DATA_W-1:0]     Din1,
  input  logic [DATA_W-1:0]     Din2,
  input  logic                  Start_N,
  input  logic                  Hold,
  input  logic                  Abort,
  output logic                  Ready,
  output logic [NUM_PHASES-1:0] Phase,
  output logic [IDX_W-1:0]      PhaseIdx,
  output logic [DATA_W-1:0]     Dout,
  output logic                  Done,
  output logic                  Aborted
);

  t_state              r_state;
  t_state              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   w_a_nxt;
  logic [DATA_W-1:0]   w_b_nxt;
  logic                r_start_hist;
  logic                r_done;
  logic                r_aborted;
  logic                w_done_nxt;
  logic                w_aborted_nxt;

  logic                w_start_ev;
  logic                w_running;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CNT_W-1:0]    w_cur_time;
  t_op                 w_cur_op;
  logic                w_phase_end;
  logic                w_last_phase;
  logic [DATA_W-1:0]   w_alu_result;

  // r_start_hist holds Start_N from the previous edge. It resets to 0 so a
  // Start_N held low across reset release is not seen as a falling edge.
  assign w_start_ev = ~Start_N & r_start_hist;
  assign w_running  = (r_state == S_RUN);

  // Per-phase duration and op lookup, built as a mux over constant slices.
  always_comb begin
    w_cur_time = '0;
    w_cur_op   = OP_OR;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_time = PHASE_TIME[i*CNT_W +: CNT_W];
        w_cur_op   = psm_op_from_bits(PHASE_OP[i*OP_W +: OP_W]);
      end
    end
  end

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_phase_end  = (w_cnt_inc == w_cur_time);
  assign w_last_phase = (r_idx == IDX_W'(NUM_PHASES - 1));

  // Next-state logic. Priority while running: Abort, then Hold, then count.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;

    unique case (r_state)
      S_READY: begin
        // Abort here only matters in that it swallows a coincident start.
        if (w_start_ev && !Abort) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_a_nxt     = Din1;
          w_b_nxt     = Din2;
        end
      end

      S_RUN: begin
        if (Abort) begin
          w_state_nxt   = S_READY;
          w_idx_nxt     = '0;
          w_cnt_nxt     = '0;
          w_aborted_nxt = 1'b1;
        end else if (!Hold) begin
          if (w_phase_end) begin
            w_cnt_nxt = '0;
            if (w_last_phase) begin
              w_state_nxt = S_READY;
              w_idx_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      default: begin
        w_state_nxt = S_READY;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state      <= S_READY;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_start_hist <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_start_hist <= Start_N;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  psm_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (w_cur_op),
    .o_result (w_alu_result)
  );

  always_comb begin
    Phase = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      Phase[i] = w_running && (r_idx == IDX_W'(i));
    end
  end

  // Captured operands persist while idle; the result is masked instead.
  assign Ready    = ~w_running;
  assign PhaseIdx = w_running ? r_idx : '0;
  assign Dout     = w_running ? w_alu_result : '0;
  assign Done     = r_done;
  assign Aborted  = r_aborted;

endmodule

// File: tb/tb_psm_seq.sv
// tb/tb_psm_seq.sv - self-checking bench for psm_seq with behavioural model

module tb_psm_seq;

  localparam int DW    = 3;
  localparam int NP    = 3;
  localparam int CW    = 8;
  localparam int TOTAL = 12;

  logic          Clock   = 1'b0;
  logic          Reset_N = 1'b0;
  logic          Start_N = 1'b0;
  logic          Hold    = 1'b0;
  logic          Abort   = 1'b0;
  logic [DW-1:0] Din1    = '0;
  logic [DW-1:0] Din2    = '0;

  logic          Ready;
  logic [NP-1:0] Phase;
  logic [2:0]    PhaseIdx;
  logic [DW-1:0] Dout;
  logic          Done;
  logic          Aborted;

  logic [DW-1:0] u_din1 = 3'b110;
  logic [DW-1:0] u_din2 = 3'b011;
  logic          u_Ready;
  logic [0:0]    u_Phase;
  logic [2:0]    u_PhaseIdx;
  logic [DW-1:0] u_Dout;
  logic          u_Done;
  logic          u_Aborted;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 Clock = ~Clock;

  psm_seq #(
    .DATA_W(DW), .NUM_PHASES(NP), .CNT_W(CW),
    .PHASE_TIME({8'd6, 8'd2, 8'd4}), .PHASE_OP({2'd2, 2'd1, 2'd0})
  ) dut (
    .Clock(Clock), .Reset_N(Reset_N), .Din1(Din1), .Din2(Din2),
    .Start_N(Start_N), .Hold(Hold), .Abort(Abort),
    .Ready(Ready), .Phase(Phase), .PhaseIdx(PhaseIdx), .Dout(Dout),
    .Done(Done), .Aborted(Aborted)
  );

  psm_seq #(
    .DATA_W(DW), .NUM_PHASES(1), .CNT_W(CW),
    .PHASE_TIME(8'd1), .PHASE_OP(2'd3)
  ) dut1 (
    .Clock(Clock), .Reset_N(Reset_N), .Din1(u_din1), .Din2(u_din2),
    .Start_N(Start_N), .Hold(Hold), .Abort(Abort),
    .Ready(u_Ready), .Phase(u_Phase), .PhaseIdx(u_PhaseIdx), .Dout(u_Dout),
    .Done(u_Done), .Aborted(u_Aborted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks active (non-held) cycles since start; phase follows from the
  // cumulative phase durations.
  int            m_time [NP] = '{4, 2, 6};
  int            m_op   [NP] = '{0, 1, 2};
  bit            m_run, m_prev, m_done, m_ab;
  int            m_elapsed;
  logic [DW-1:0] m_a, m_b;

  function automatic logic [DW-1:0] op_eval(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      0:       return a | b;
      1:       return a ^ b;
      2:       return ~(~a & b);
      default: return a & b;
    endcase
  endfunction

  function automatic int phase_of(input int e);
    int acc = 0;
    for (int i = 0; i < NP; i++) begin
      acc += m_time[i];
      if (e < acc) return i;
    end
    return NP - 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_done = 0; m_ab = 0; m_elapsed = 0; m_a = '0; m_b = '0;
  endtask

  task automatic model_step();
    bit start_ev;
    start_ev = !Start_N && m_prev;
    m_prev   = Start_N;
    m_done   = 0;
    m_ab     = 0;
    if (!m_run) begin
      if (start_ev && !Abort) begin
        m_run = 1; m_a = Din1; m_b = Din2; m_elapsed = 0;
      end
    end else if (Abort) begin
      m_run = 0; m_ab = 1; m_elapsed = 0;
    end else if (!Hold) begin
      m_elapsed++;
      if (m_elapsed == TOTAL) begin
        m_run = 0; m_done = 1; m_elapsed = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clock or negedge Reset_N);
      if (!Reset_N) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (chk_en) begin : cmp
        int p;
        p = phase_of(m_elapsed);
        check("cmp_ready",   32'(Ready),    32'(!m_run));
        check("cmp_phase",   32'(Phase),    m_run ? (32'd1 << p) : 32'd0);
        check("cmp_idx",     32'(PhaseIdx), m_run ? 32'(p) : 32'd0);
        check("cmp_dout",    32'(Dout),     m_run ? 32'(op_eval(m_op[p], m_a, m_b)) : 32'd0);
        check("cmp_done",    32'(Done),     32'(m_done));
        check("cmp_aborted", 32'(Aborted),  32'(m_ab));
      end
    end
  end

  task automatic do_start(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge Clock);
    Start_N = 1'b1; Din1 = a; Din2 = b;
    @(negedge Clock);
    Start_N = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int ph1, first_ready, done_cnt;
    bit seen_done;
    logic [31:0] exp_d, exp_i;

    repeat (3) @(negedge Clock);
    chk_en = 1'b1;
    check("rst_ready",   32'(Ready),   32'd1);
    check("rst_phase",   32'(Phase),   32'd0);
    check("rst_dout",    32'(Dout),    32'd0);
    check("rst_done",    32'(Done),    32'd0);
    check("rst_aborted", 32'(Aborted), 32'd0);

    // Start_N held low through reset release: no start.
    @(negedge Clock);
    Reset_N = 1'b1;
    repeat (4) @(negedge Clock);
    check("no_start_after_rst", 32'(Ready), 32'd1);

    // Basic run: 4 x 111, 2 x 110, 6 x 101, then Done with Ready.
    do_start(3'b101, 3'b011);
    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      exp_d = (i < 4) ? 32'd7 : (i < 6) ? 32'd6 : (i < 12) ? 32'd5 : 32'd0;
      exp_i = (i < 4) ? 32'd0 : (i < 6) ? 32'd1 : (i < 12) ? 32'd2 : 32'd0;
      check("t1_dout",  32'(Dout),     exp_d);
      check("t1_idx",   32'(PhaseIdx), exp_i);
      check("t1_ready", 32'(Ready),    (i >= 12) ? 32'd1 : 32'd0);
      check("t1_done",  32'(Done),     (i == 12) ? 32'd1 : 32'd0);
      if (i == 0) begin
        Din1 = 3'b000; Din2 = 3'b000;
        check("u_dout",  32'(u_Dout),     32'd2);
        check("u_ready", 32'(u_Ready),    32'd0);
        check("u_phase", 32'(u_Phase),    32'd1);
        check("u_idx",   32'(u_PhaseIdx), 32'd0);
      end
      if (i == 1) begin
        check("u_done_pulse", 32'(u_Done),    32'd1);
        check("u_ready_done", 32'(u_Ready),   32'd1);
        check("u_dout_idle",  32'(u_Dout),    32'd0);
        check("u_no_abort",   32'(u_Aborted), 32'd0);
      end
      if (i == 2) check("u_done_once", 32'(u_Done), 32'd0);
    end

    // Hold 3 cycles in phase 1: phase 1 lasts 5 cycles, run 15 cycles.
    do_start(3'b101, 3'b011);
    ph1 = 0; first_ready = -1; seen_done = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clock);
      if (!Ready && PhaseIdx == 3'd1) begin
        ph1++;
        check("hold_dout_stable", 32'(Dout), 32'd6);
      end
      if (Ready && first_ready < 0) begin
        first_ready = i;
        check("hold_done", 32'(Done), 32'd1);
      end
      if (i == 4) Hold = 1'b1;
      if (i == 7) Hold = 1'b0;
    end
    check("hold_ph1_len", 32'(ph1), 32'd5);
    check("hold_total",   32'(first_ready), 32'd15);

    // Abort in cycle 2 of phase 2.
    do_start(3'b101, 3'b011);
    seen_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      if (Done) seen_done = 1;
      if (i == 7) begin
        check("abort_pre_idx", 32'(PhaseIdx), 32'd2);
        Abort = 1'b1;
      end
      if (i == 8) begin
        check("abort_ready", 32'(Ready),   32'd1);
        check("abort_pulse", 32'(Aborted), 32'd1);
        check("abort_dout",  32'(Dout),    32'd0);
        Abort = 1'b0;
      end
      if (i == 9) check("abort_once", 32'(Aborted), 32'd0);
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    // Second falling edge during a run is ignored and not queued.
    do_start(3'b101, 3'b011);
    first_ready = -1; done_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clock);
      if (Done) done_cnt++;
      if (Ready && first_ready < 0) first_ready = i;
      if (i == 2) Start_N = 1'b1;
      if (i == 3) Start_N = 1'b0;
    end
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_len",      32'(first_ready), 32'd12);
    check("ign_idle",     32'(Ready), 32'd1);
    do_start(3'b010, 3'b100);
    @(negedge Clock);
    check("fresh_ready", 32'(Ready), 32'd0);
    check("fresh_dout",  32'(Dout),  32'd6);

    // Reset asserted mid phase 1: outputs return asynchronously.
    repeat (4) @(negedge Clock);
    check("mid_idx", 32'(PhaseIdx), 32'd1);
    #2;
    Reset_N = 1'b0;
    #1;
    check("arst_ready",   32'(Ready),    32'd1);
    check("arst_phase",   32'(Phase),    32'd0);
    check("arst_idx",     32'(PhaseIdx), 32'd0);
    check("arst_dout",    32'(Dout),     32'd0);
    check("arst_done",    32'(Done),     32'd0);
    check("arst_aborted", 32'(Aborted),  32'd0);
    @(negedge Clock);
    Reset_N = 1'b1;
    repeat (3) @(negedge Clock);
    check("arst_no_start", 32'(Ready), 32'd1);

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      if ($urandom_range(0, 3) == 0) Start_N = ~Start_N;
      Hold  = ($urandom_range(0, 99) < 15);
      Abort = ($urandom_range(0, 99) < 3);
      Din1  = DW'($urandom);
      Din2  = DW'($urandom);
      if (!Reset_N) Reset_N = 1'b1;
      else if ($urandom_range(0, 499) == 0) Reset_N = 1'b0;
    end

    @(negedge Clock);
    Hold = 1'b0; Abort = 1'b0; Reset_N = 1'b1;
    repeat (2) @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
